// File: rtl/rst_seq.sv
// Reset sequencer: waits for stable PLL lock, releases a registered
// active-low system reset, then drives a periodic one-cycle tick.
module rst_seq #(
  parameter int HOLD_CYCLES = 1024,
  parameter int TICK_DIV    = 96,
  parameter int LOSS_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              lock_i,
  input  logic              soft_rst_i,
  output logic              rst_n_o,
  output logic              tick_o,
  output logic [LOSS_W-1:0] loss_cnt_o,
  output logic [1:0]        state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state;
  logic            sync_q;
  logic            lock_s;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   tick_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= lock_i;
      lock_s <= sync_q;
    end
  end

  // rst_n_o, tick_o and tick_cnt fall back to idle unless RUN is kept
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= WAIT;
      hold_cnt   <= '0;
      tick_cnt   <= '0;
      rst_n_o    <= 1'b0;
      tick_o     <= 1'b0;
      loss_cnt_o <= '0;
    end else begin
      rst_n_o  <= 1'b0;
      tick_o   <= 1'b0;
      tick_cnt <= '0;
      case (state)
        WAIT: begin
          if (lock_s && !soft_rst_i) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (!lock_s || soft_rst_i) begin
            state <= WAIT;
          end else if (hold_cnt == HOLD_LAST) begin
            state   <= RUN;
            rst_n_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (soft_rst_i) begin
            state <= WAIT;
          end else if (!lock_s) begin
            state <= WAIT;
            if (~&loss_cnt_o) begin
              loss_cnt_o <= loss_cnt_o + 1'b1;
            end
          end else begin
            rst_n_o  <= 1'b1;
            tick_o   <= (tick_cnt == TICK_LAST);
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: stimulus queues hand-computed expected
// outputs per edge count; monitors compare on negedge or async event.
module tb_rst_seq;

  localparam int H  = 4;
  localparam int T  = 3;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          lock_i;
  logic          soft_rst_i;
  logic          rst_n_o;
  logic          tick_o;
  logic [LW-1:0] loss_cnt_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  rst_seq #(
    .HOLD_CYCLES(H),
    .TICK_DIV(T),
    .LOSS_W(LW)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n_i),
    .lock_i(lock_i),
    .soft_rst_i(soft_rst_i),
    .rst_n_o(rst_n_o),
    .tick_o(tick_o),
    .loss_cnt_o(loss_cnt_o),
    .state_o(state_o)
  );

  typedef struct {
    int            cyc;
    logic          rn;
    logic          tk;
    bit            ct;
    logic [LW-1:0] loss;
    logic [1:0]    st;
    string         nm;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  int   edges  = 0;
  int   checks = 0;
  int   errors = 0;
  event async_ev;

  initial forever begin
    @(posedge clk);
    edges++;
  end

  task automatic cmp(input exp_t x);
    checks++;
    if (rst_n_o !== x.rn || (x.ct && tick_o !== x.tk) ||
        loss_cnt_o !== x.loss || state_o !== x.st) begin
      errors++;
      $display("FAIL %s cyc=%0d got rst_n=%b tick=%b loss=%0d state=%0d want rst_n=%b tick=%b loss=%0d state=%0d",
               x.nm, x.cyc, rst_n_o, tick_o, loss_cnt_o, state_o,
               x.rn, x.tk, x.loss, x.st);
    end
  endtask

  // cyc < 0 marks a check taken right after an async reset assertion
  task automatic push(input int c, input int rn, input int tk,
                      input int ct, input int l, input int s,
                      input string nm);
    exp_t x;
    int   k;
    x.cyc  = c;
    x.rn   = (rn != 0);
    x.tk   = (tk != 0);
    x.ct   = (ct != 0);
    x.loss = LW'(l);
    x.st   = 2'(s);
    x.nm   = nm;
    if (c < 0) begin
      aq.push_back(x);
    end else begin
      k = 0;
      while (k < q.size() && q[k].cyc <= c) k++;
      q.insert(k, x);
    end
  endtask

  task automatic to_cyc(input int c);
    while (edges < c) @(negedge clk);
    #1;
  endtask

  initial forever begin
    exp_t x;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= edges) begin
      x = q.pop_front();
      if (x.cyc < edges) begin
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d now=%0d", x.nm, x.cyc, edges);
      end else begin
        cmp(x);
      end
    end
  end

  initial forever begin
    @(async_ev);
    while (aq.size() > 0) cmp(aq.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL timeout edges=%0d pending=%0d", edges, q.size());
    $fatal(1, "bench timeout");
  end

  initial begin
    int e;
    int lb;
    int la;
    rst_n_i    = 1'b0;
    lock_i     = 1'b0;
    soft_rst_i = 1'b0;
    @(negedge clk);
    #1;
    push(edges + 1, 0, 0, 1, 0, 0, "reset");
    to_cyc(edges + 2);
    rst_n_i = 1'b1;
    e = edges;
    push(e + 2, 0, 0, 1, 0, 0, "wait_nolock");
    to_cyc(e + 3);

    // acquisition and tick cadence
    e = edges;
    lock_i = 1'b1;
    push(e + 2, 0, 0, 1, 0, 0, "acq_sync");
    push(e + 3, 0, 0, 1, 0, 1, "acq_hold");
    push(e + 6, 0, 0, 1, 0, 1, "acq_hold_end");
    for (int k = 0; k <= 10; k++)
      push(e + 7 + k, 1, int'(k > 0 && k % T == 0), 1, 0, 2, "acq_tick");
    to_cyc(e + 18);

    // soft reset alone in RUN
    e = edges;
    soft_rst_i = 1'b1;
    push(e + 1, 0, 0, 1, 0, 0, "soft_wait");
    push(e + 2, 0, 0, 1, 0, 1, "soft_hold");
    push(e + 5, 0, 0, 1, 0, 1, "soft_hold_end");
    push(e + 6, 1, 0, 1, 0, 2, "soft_release");
    to_cyc(e + 1);
    soft_rst_i = 1'b0;
    to_cyc(e + 10);

    // soft reset in the same cycle lock_s falls
    e = edges;
    lock_i = 1'b0;
    push(e + 2, 1, 0, 0, 0, 2, "sl_run");
    to_cyc(e + 2);
    soft_rst_i = 1'b1;
    push(e + 3, 0, 0, 1, 0, 0, "sl_wait");
    push(e + 6, 0, 0, 1, 0, 0, "sl_stay");
    to_cyc(e + 3);
    soft_rst_i = 1'b0;
    to_cyc(e + 8);

    // lock drop for 3 cycles during HOLD
    e = edges;
    lock_i = 1'b1;
    push(e + 3, 0, 0, 1, 0, 1, "hi_hold");
    to_cyc(e + 3);
    lock_i = 1'b0;
    push(e + 5, 0, 0, 1, 0, 1, "hi_hold2");
    push(e + 6, 0, 0, 1, 0, 0, "hi_drop");
    to_cyc(e + 6);
    lock_i = 1'b1;
    push(e + 8, 0, 0, 1, 0, 0, "hi_wait");
    push(e + 9, 0, 0, 1, 0, 1, "hi_rehold");
    push(e + 12, 0, 0, 1, 0, 1, "hi_hold_end");
    push(e + 13, 1, 0, 1, 0, 2, "hi_release");
    to_cyc(e + 15);

    // repeated lock loss in RUN up to saturation
    for (int i = 0; i < 260; i++) begin
      lb = (i < 255) ? i : 255;
      la = (i + 1 < 255) ? i + 1 : 255;
      e = edges;
      lock_i = 1'b0;
      push(e + 2, 1, 0, 0, lb, 2, "loss_run");
      push(e + 3, 0, 0, 1, la, 0, "loss_drop");
      push(e + 5, 0, 0, 1, la, 0, "loss_low");
      to_cyc(e + 5);
      lock_i = 1'b1;
      push(e + 11, 0, 0, 1, la, 1, "loss_hold");
      push(e + 12, 1, 0, 1, la, 2, "loss_release");
      to_cyc(e + 13);
    end

    // async reset between edges while running
    to_cyc(edges + 4);
    #2;
    rst_n_i = 1'b0;
    #1;
    push(-1, 0, 0, 1, 0, 0, "async_rst");
    ->async_ev;
    @(negedge clk);
    #1;
    e = edges;
    push(e + 1, 0, 0, 1, 0, 0, "rst_hold");
    to_cyc(e + 2);
    rst_n_i = 1'b1;
    e = edges;
    push(e + 2, 0, 0, 1, 0, 0, "rel_wait");
    push(e + 3, 0, 0, 1, 0, 1, "rel_hold");
    push(e + 6, 0, 0, 1, 0, 1, "rel_hold_end");
    push(e + 7, 1, 0, 1, 0, 2, "rel_run");
    push(e + 10, 1, 1, 1, 0, 2, "rel_tick");
    to_cyc(e + 12);

    repeat (20) if (q.size() > 0) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
